// File: rtl/ultrasonic_echo_emulator_pkg.sv
// ============================================================================
// ultrasonic_pkg : state encoding and default timing shared with the ranging
//                  controller (50 MHz, 2900 cycles per cm).
// Revision: 1.0
// ============================================================================
`default_nettype none

package ultrasonic_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    TRIG_HI = 3'd1,
    BURST   = 3'd2,
    ECHO    = 3'd3,
    HOLDOFF = 3'd4
  } state_t;

  localparam int DEF_CYC_PER_CM   = 2900;
  localparam int DEF_TRIG_MIN_CYC = 500;
  localparam int DEF_TIMEOUT_CYC  = 1900000;

  localparam int TMR_W = 21;
  localparam int CM_W  = 9;
  localparam int SUB_W = 12;

endpackage

`default_nettype wire

// File: rtl/ultrasonic_echo_emulator_sync_edge.sv
// ============================================================================
// sync_edge : 2-FF synchronizer with rise/fall pulses on the synchronized level.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d_in,
  output logic sync_out,
  output logic rise,
  output logic fall
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = d_in;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign sync_out = sync_q;
  assign rise     = sync_q & ~prev_q;
  assign fall     = ~sync_q & prev_q;

endmodule

`default_nettype wire

// File: rtl/ultrasonic_echo_emulator.sv
// ============================================================================
// ultrasonic_echo_emulator : HC-SR04 model, trigger in, distance-coded echo out.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ultrasonic_echo_emulator
  import ultrasonic_pkg::*;
#(
  parameter int TRIG_MIN_CYC = DEF_TRIG_MIN_CYC,
  parameter int BURST_CYC    = 10000,
  parameter int CYC_PER_CM   = DEF_CYC_PER_CM,
  parameter int MIN_CM       = 2,
  parameter int MAX_CM       = 400,
  parameter int TIMEOUT_CYC  = DEF_TIMEOUT_CYC,
  parameter int HOLDOFF_CYC  = 500000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            trigger,
  input  logic [CM_W-1:0] distance_cm,
  input  logic            obstacle,
  output logic            echo,
  output logic            busy,
  output logic            trig_short,
  output logic [7:0]      echo_count
);

  localparam int WID_W = $clog2(TRIG_MIN_CYC + 1);

  logic trig_s, trig_rise, trig_fall;

  sync_edge u_trig_sync (
    .clk      (clk),
    .rst_n    (reset),
    .d_in     (trigger),
    .sync_out (trig_s),
    .rise     (trig_rise),
    .fall     (trig_fall)
  );

  state_t              state_q, state_d;
  logic [WID_W-1:0]    width_q, width_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic [CM_W-1:0]     cm_q, cm_d;
  logic [SUB_W-1:0]    sub_q, sub_d;
  logic                timeout_q, timeout_d;
  logic [CM_W-1:0]     dist_q, dist_d;
  logic                obst_q, obst_d;
  logic                echo_q, echo_d;
  logic                busy_q, busy_d;
  logic                short_q, short_d;
  logic [7:0]          count_q, count_d;

  logic                w_timeout;
  logic [CM_W-1:0]     w_cm;
  logic                w_sub_wrap;
  logic                w_echo_done;

  // Echo length is decided from the values latched at trigger acceptance.
  assign w_timeout   = !obst_q || (dist_q > CM_W'(MAX_CM));
  assign w_cm        = (dist_q < CM_W'(MIN_CM)) ? CM_W'(MIN_CM) : dist_q;
  assign w_sub_wrap  = (sub_q == SUB_W'(CYC_PER_CM - 1));
  assign w_echo_done = timeout_q ? (tmr_q == TMR_W'(TIMEOUT_CYC - 1))
                                 : ((cm_q == CM_W'(1)) && w_sub_wrap);

  always_comb begin
    state_d   = state_q;
    width_d   = width_q;
    tmr_d     = tmr_q;
    cm_d      = cm_q;
    sub_d     = sub_q;
    timeout_d = timeout_q;
    dist_d    = dist_q;
    obst_d    = obst_q;
    echo_d    = echo_q;
    busy_d    = busy_q;
    short_d   = 1'b0;
    count_d   = count_q;

    case (state_q)
      IDLE: begin
        // The rise cycle itself counts as the first high cycle.
        if (trig_rise) begin
          width_d = WID_W'(1);
          state_d = TRIG_HI;
        end
      end
      TRIG_HI: begin
        if (trig_fall) begin
          if (width_q >= WID_W'(TRIG_MIN_CYC)) begin
            dist_d  = distance_cm;
            obst_d  = obstacle;
            busy_d  = 1'b1;
            tmr_d   = '0;
            state_d = BURST;
          end else begin
            short_d = 1'b1;
            state_d = IDLE;
          end
        end else if (trig_s && (width_q != WID_W'(TRIG_MIN_CYC))) begin
          width_d = width_q + WID_W'(1);
        end
      end
      BURST: begin
        if (tmr_q == TMR_W'(BURST_CYC - 1)) begin
          echo_d    = 1'b1;
          tmr_d     = '0;
          timeout_d = w_timeout;
          cm_d      = w_cm;
          sub_d     = '0;
          state_d   = ECHO;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      ECHO: begin
        if (w_echo_done) begin
          echo_d  = 1'b0;
          count_d = count_q + 8'd1;
          tmr_d   = '0;
          state_d = HOLDOFF;
        end else if (timeout_q) begin
          tmr_d = tmr_q + TMR_W'(1);
        end else if (w_sub_wrap) begin
          sub_d = '0;
          cm_d  = cm_q - CM_W'(1);
        end else begin
          sub_d = sub_q + SUB_W'(1);
        end
      end
      HOLDOFF: begin
        if (tmr_q == TMR_W'(HOLDOFF_CYC - 1)) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      width_q   <= '0;
      tmr_q     <= '0;
      cm_q      <= '0;
      sub_q     <= '0;
      timeout_q <= 1'b0;
      dist_q    <= '0;
      obst_q    <= 1'b0;
      echo_q    <= 1'b0;
      busy_q    <= 1'b0;
      short_q   <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      width_q   <= width_d;
      tmr_q     <= tmr_d;
      cm_q      <= cm_d;
      sub_q     <= sub_d;
      timeout_q <= timeout_d;
      dist_q    <= dist_d;
      obst_q    <= obst_d;
      echo_q    <= echo_d;
      busy_q    <= busy_d;
      short_q   <= short_d;
      count_q   <= count_d;
    end
  end

  assign echo       = echo_q;
  assign busy       = busy_q;
  assign trig_short = short_q;
  assign echo_count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_ultrasonic_echo_emulator.sv
// ============================================================================
// tb_ultrasonic_echo_emulator : directed bench with scaled-down timing.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ultrasonic_echo_emulator;

  localparam int P_TRIG_MIN = 20;
  localparam int P_BURST    = 100;
  localparam int P_CPC      = 29;
  localparam int P_MIN      = 2;
  localparam int P_MAX      = 400;
  localparam int P_TO       = 3000;
  localparam int P_HOLD     = 200;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       trigger = 1'b0;
  logic [8:0] distance_cm = 9'd0;
  logic       obstacle = 1'b0;
  logic       echo;
  logic       busy;
  logic       trig_short;
  logic [7:0] echo_count;

  int checks = 0;
  int failures = 0;
  int short_cnt = 0;
  int exp_count = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (trig_short === 1'b1) short_cnt <= short_cnt + 1;

  ultrasonic_echo_emulator #(
    .TRIG_MIN_CYC (P_TRIG_MIN),
    .BURST_CYC    (P_BURST),
    .CYC_PER_CM   (P_CPC),
    .MIN_CM       (P_MIN),
    .MAX_CM       (P_MAX),
    .TIMEOUT_CYC  (P_TO),
    .HOLDOFF_CYC  (P_HOLD)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .trigger     (trigger),
    .distance_cm (distance_cm),
    .obstacle    (obstacle),
    .echo        (echo),
    .busy        (busy),
    .trig_short  (trig_short),
    .echo_count  (echo_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Trigger high for exactly n clock edges.
  task automatic pulse(input int n);
    tick();
    trigger = 1'b1;
    repeat (n) tick();
    trigger = 1'b0;
  endtask

  // Cycles until the chosen output (0 = echo, 1 = busy) reaches val.
  task automatic wait_sig(input int sel, input logic val, input int maxc, output int c);
    logic hit;
    hit = 1'b0;
    c = 0;
    while (!hit && c < maxc) begin
      tick();
      c++;
      hit = (((sel == 0) ? echo : busy) === val);
    end
    if (!hit) begin
      checks++;
      failures++;
      $display("FAIL wait_bound sel=%0d: level %0b not reached within %0d cycles", sel, val, maxc);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) tick();
    checks++; if (echo !== 1'b0) begin failures++; $display("FAIL reset_echo: got %b expected 0", echo); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (trig_short !== 1'b0) begin failures++; $display("FAIL reset_short: got %b expected 0", trig_short); end
    checks++; if (echo_count !== 8'd0) begin failures++; $display("FAIL reset_count: got %0d expected 0", echo_count); end
    reset = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_accept();
    int c;
    distance_cm = 9'd10;
    obstacle = 1'b1;
    pulse(30);
    wait_sig(1, 1'b1, 50, c);
    checks++; if (c != 3) begin failures++; $display("FAIL accept_busy_rise: got %0d cycles expected 3", c); end
    wait_sig(0, 1'b1, 500, c);
    checks++; if (c != P_BURST) begin failures++; $display("FAIL accept_burst: got %0d expected %0d", c, P_BURST); end
    wait_sig(0, 1'b0, 5000, c);
    checks++; if (c != 10 * P_CPC) begin failures++; $display("FAIL accept_width: got %0d expected %0d", c, 10 * P_CPC); end
    exp_count++;
    checks++; if (echo_count !== 8'(exp_count)) begin failures++; $display("FAIL accept_count: got %0d expected %0d", echo_count, exp_count); end
    wait_sig(1, 1'b0, 1000, c);
    checks++; if (c != P_HOLD) begin failures++; $display("FAIL accept_holdoff: got %0d expected %0d", c, P_HOLD); end
  endtask

  task automatic test_short();
    int s0;
    logic r3, r4, seen;
    s0 = short_cnt;
    r3 = 1'b0; r4 = 1'b1; seen = 1'b0;
    pulse(15);
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 3) r3 = trig_short;
      if (i == 4) r4 = trig_short;
      if (busy !== 1'b0 || echo !== 1'b0) seen = 1'b1;
    end
    checks++; if (r3 !== 1'b1) begin failures++; $display("FAIL short_pulse: got %b expected 1", r3); end
    checks++; if (r4 !== 1'b0) begin failures++; $display("FAIL short_pulse_end: got %b expected 0", r4); end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL short_no_echo: got busy/echo activity %b expected 0", seen); end
    checks++; if (short_cnt - s0 != 1) begin failures++; $display("FAIL short_count: got %0d pulse cycles expected 1", short_cnt - s0); end
  endtask

  task automatic test_width_boundary();
    int s0, c;
    s0 = short_cnt;
    distance_cm = 9'd10;
    obstacle = 1'b1;
    pulse(P_TRIG_MIN - 1);
    repeat (10) tick();
    checks++; if (short_cnt - s0 != 1) begin failures++; $display("FAIL bound_reject: got %0d short pulses expected 1", short_cnt - s0); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bound_reject_busy: got %b expected 0", busy); end
    pulse(P_TRIG_MIN);
    wait_sig(1, 1'b1, 50, c);
    checks++; if (c != 3) begin failures++; $display("FAIL bound_accept: got %0d cycles expected 3", c); end
    checks++; if (short_cnt - s0 != 1) begin failures++; $display("FAIL bound_accept_short: got %0d short pulses expected 1", short_cnt - s0); end
    wait_sig(0, 1'b1, 500, c);
    wait_sig(0, 1'b0, 5000, c);
    checks++; if (c != 10 * P_CPC) begin failures++; $display("FAIL bound_width: got %0d expected %0d", c, 10 * P_CPC); end
    exp_count++;
    wait_sig(1, 1'b0, 1000, c);
  endtask

  task automatic test_clamp_timeout();
    int c;
    int dists [3] = '{1, 450, 50};
    logic obsts [3] = '{1'b1, 1'b1, 1'b0};
    int expw [3] = '{2 * P_CPC, P_TO, P_TO};
    for (int i = 0; i < 3; i++) begin
      distance_cm = 9'(dists[i]);
      obstacle = obsts[i];
      pulse(30);
      wait_sig(1, 1'b1, 50, c);
      wait_sig(0, 1'b1, 500, c);
      wait_sig(0, 1'b0, 5000, c);
      checks++; if (c != expw[i]) begin failures++; $display("FAIL clamp_width[%0d]: got %0d expected %0d", i, c, expw[i]); end
      exp_count++;
      checks++; if (echo_count !== 8'(exp_count)) begin failures++; $display("FAIL clamp_count[%0d]: got %0d expected %0d", i, echo_count, exp_count); end
      wait_sig(1, 1'b0, 1000, c);
    end
  endtask

  task automatic test_busy_reject();
    int s0, c;
    s0 = short_cnt;
    distance_cm = 9'd10;
    obstacle = 1'b1;
    pulse(30);
    wait_sig(1, 1'b1, 50, c);
    repeat (10) tick();
    pulse(30);
    wait_sig(0, 1'b1, 500, c);
    checks++; if (c + 41 != P_BURST) begin failures++; $display("FAIL reject_burst: got %0d expected %0d", c + 41, P_BURST); end
    repeat (20) tick();
    distance_cm = 9'd200;
    wait_sig(0, 1'b0, 10000, c);
    checks++; if (c + 20 != 10 * P_CPC) begin failures++; $display("FAIL latch_width: got %0d expected %0d", c + 20, 10 * P_CPC); end
    exp_count++;
    checks++; if (echo_count !== 8'(exp_count)) begin failures++; $display("FAIL latch_count: got %0d expected %0d", echo_count, exp_count); end
    repeat (50) tick();
    pulse(30);
    wait_sig(1, 1'b0, 1000, c);
    checks++; if (c + 81 != P_HOLD) begin failures++; $display("FAIL reject_holdoff: got %0d expected %0d", c + 81, P_HOLD); end
    checks++; if (short_cnt != s0) begin failures++; $display("FAIL reject_short: got %0d short pulses expected 0", short_cnt - s0); end
  endtask

  task automatic test_holdoff_high();
    int s0, c;
    s0 = short_cnt;
    distance_cm = 9'd10;
    obstacle = 1'b1;
    pulse(30);
    wait_sig(1, 1'b1, 50, c);
    wait_sig(0, 1'b1, 500, c);
    wait_sig(0, 1'b0, 5000, c);
    exp_count++;
    repeat (150) tick();
    trigger = 1'b1;
    wait_sig(1, 1'b0, 1000, c);
    checks++; if (c + 150 != P_HOLD) begin failures++; $display("FAIL held_holdoff: got %0d expected %0d", c + 150, P_HOLD); end
    repeat (40) tick();
    trigger = 1'b0;
    repeat (10) tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL held_no_accept: got busy %b expected 0", busy); end
    checks++; if (short_cnt != s0) begin failures++; $display("FAIL held_short: got %0d short pulses expected 0", short_cnt - s0); end
  endtask

  task automatic test_reset_mid();
    int c;
    logic seen;
    distance_cm = 9'd20;
    obstacle = 1'b1;
    pulse(30);
    wait_sig(1, 1'b1, 50, c);
    wait_sig(0, 1'b1, 500, c);
    repeat (290) tick();
    checks++; if (echo !== 1'b1) begin failures++; $display("FAIL mid_echo_high: got %b expected 1", echo); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (echo !== 1'b0) begin failures++; $display("FAIL mid_reset_echo: got %b expected 0", echo); end
    checks++; if (echo_count !== 8'd0) begin failures++; $display("FAIL mid_reset_count: got %0d expected 0", echo_count); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_reset_busy: got %b expected 0", busy); end
    exp_count = 0;
    repeat (3) tick();
    reset = 1'b1;
    seen = 1'b0;
    repeat (700) begin
      tick();
      if (echo !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL mid_no_resume: got activity %b expected 0", seen); end
    pulse(30);
    wait_sig(1, 1'b1, 50, c);
    wait_sig(0, 1'b1, 500, c);
    wait_sig(0, 1'b0, 5000, c);
    checks++; if (c != 20 * P_CPC) begin failures++; $display("FAIL mid_after_width: got %0d expected %0d", c, 20 * P_CPC); end
    exp_count++;
    checks++; if (echo_count !== 8'(exp_count)) begin failures++; $display("FAIL mid_after_count: got %0d expected %0d", echo_count, exp_count); end
    wait_sig(1, 1'b0, 1000, c);
  endtask

  initial begin
    test_reset();
    test_accept();
    test_short();
    test_width_boundary();
    test_clamp_timeout();
    test_busy_reject();
    test_holdoff_high();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/ultrasonic_echo_emulator.md
# ultrasonic_echo_emulator

Cycle-accurate HC-SR04 sensor model for the ultrasonic ranging path: it accepts the trigger pulse from the ranging controller and returns an echo pulse whose width encodes a programmed distance. It sits on the sensor side of the trigger/echo pins and replaces the physical sensor for hardware-in-the-loop bring-up and regression. Both the echo timing and the timeout timing match the ranging controller's scale of 2900 cycles per cm at 50 MHz.

## Interface
Parameters:
- TRIG_MIN_CYC, 500: minimum trigger high time in cycles (10 µs) for a pulse to be accepted
- BURST_CYC, 10000: delay in cycles from accepted trigger fall to echo rise (8-cycle 40 kHz burst, 200 µs)
- CYC_PER_CM, 2900: echo high cycles per cm
- MIN_CM, 2: distances below this are clamped up to it
- MAX_CM, 400: distances above this produce a timeout echo
- TIMEOUT_CYC, 1900000: echo width for no-obstacle or out-of-range (38 ms)
- HOLDOFF_CYC, 500000: dead time after echo fall before a new trigger is accepted (10 ms)

Ports:
- clk  in  1  system clock, 50 MHz
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- trigger  in  1  trigger from controller; asynchronous to clk, synchronized internally
- distance_cm  in  9  target distance in cm; sampled on accepted trigger fall
- obstacle  in  1  1 = target present; 0 = force timeout echo; sampled with distance_cm
- echo  out  1  echo pulse to controller, registered
- busy  out  1  high from accepted trigger fall through end of holdoff
- trig_short  out  1  one-cycle pulse when a trigger shorter than TRIG_MIN_CYC is rejected
- echo_count  out  8  count of completed echoes; wraps 255→0

## Operation
- trigger passes through a 2-FF synchronizer into trig_s; trig_q holds the previous trig_s for edge detection.
- States:
  - IDLE: on trig_s rising, clear width counter → TRIG_HI.
  - TRIG_HI: width counter increments each cycle trig_s=1, saturating at TRIG_MIN_CYC. On trig_s falling:
    - If width ≥ TRIG_MIN_CYC: latch distance/obstacle, assert busy → BURST.
    - Otherwise: pulse trig_short → IDLE.
  - BURST: count BURST_CYC cycles → ECHO.
  - ECHO: echo=1 for W cycles, then echo=0, echo_count+1 → HOLDOFF.
  - HOLDOFF: count HOLDOFF_CYC cycles, then busy=0 → IDLE.
- W is determined by the latched values:
  - obstacle=0 or d>MAX_CM: W = TIMEOUT_CYC.
  - d<MIN_CM: W = MIN_CM·CYC_PER_CM.
  - Otherwise: W = d·CYC_PER_CM.
- W is generated with a cm down-counter (9 bits) plus a sub-counter modulo CYC_PER_CM (12 bits); no multiplier. The timeout path uses a 21-bit counter.
- Trigger edges outside IDLE/TRIG_HI are ignored: no restart, no trig_short.
- Changes to distance_cm/obstacle after the latch do not affect the current echo.

## Timing
- Reset values: echo=0, busy=0, trig_short=0, echo_count=0, state=IDLE, synchronizer flops=0.
- Synchronizer latency: 2 cycles from a pin edge to trig_s.
- Let F be the clock edge at which the falling trig_s is detected in TRIG_HI with width ≥ TRIG_MIN_CYC:
  - busy rises at F.
  - echo rises at F+BURST_CYC.
  - echo falls at F+BURST_CYC+W.
  - echo_count increments on the same edge echo falls.
  - busy falls HOLDOFF_CYC cycles after echo falls.
- Width boundary: a trigger held exactly TRIG_MIN_CYC synchronized cycles is accepted; TRIG_MIN_CYC−1 cycles is rejected.
- trig_short is high for exactly one cycle, at the falling-edge detection edge.
- If trigger is still high when HOLDOFF ends, it is not accepted; acceptance requires a fresh rising edge seen in IDLE.
- Reset asserted mid-echo: echo drops asynchronously and is not reasserted after release; echo_count is cleared.

## Structure
- Package ultrasonic_pkg holds:
  - state encoding (IDLE, TRIG_HI, BURST, ECHO, HOLDOFF)
  - default timing constants shared with the ranging controller (CYC_PER_CM, TRIG_MIN_CYC, TIMEOUT_CYC)
- One sub-module, sync_edge: 2-FF synchronizer plus rise/fall pulse outputs, reset active-low async. It is reused by the echo input of the ranging controller.
- The FSM and counters stay in the top module.

## Test plan
- Accepted trigger: trigger high 600 cycles, distance_cm=10, obstacle=1 → echo rises BURST_CYC after detected fall, high exactly 29000 cycles; echo_count=1; busy falls 500000 cycles after echo falls.
- Short trigger: trigger high 400 cycles → trig_short one-cycle pulse, echo stays 0, busy stays 0.
- Width boundary: triggers of 499 and 500 synchronized cycles → first rejected with trig_short, second accepted.
- Clamp and timeout:
  - distance_cm=1 → echo 5800 cycles.
  - distance_cm=450 → echo 1900000 cycles.
  - obstacle=0, distance_cm=50 → echo 1900000 cycles.
- Busy rejection and latch: second trigger during BURST and during HOLDOFF → ignored, no trig_short. distance_cm changed 10→200 during ECHO → width stays 29000.
- Reset mid-operation: reset=0 halfway through echo → echo=0 immediately, echo_count=0. After release, a 600-cycle trigger with distance_cm=20 → echo 58000 cycles, echo_count=1.
